seconds_bcd_counter: RTL and testbench

Upstream stage of the seven-segment seconds display. It divides `clk` down to a one-second tick with a runtime-loadable prescaler compare value. It keeps a BCD seconds count from 00 to 59. Each updated count is handed to the downstream segment decoder over a valid/ready handshake, with sticky overrun detection.

---
 rtl/seconds_pkg.sv | 12 +
 rtl/seconds_bcd_counter_digit.sv | 38 +++
 rtl/seconds_bcd_counter.sv | 135 +++++++++++++
 tb/tb_seconds_bcd_counter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seconds_pkg.sv
// rtl/seconds_pkg.sv - shared BCD widths, limits and digit types for the seconds counter
package seconds_pkg;

  localparam int BCD_W    = 4;
  localparam int TENS_W   = 3;
  localparam int ONES_MAX = 9;
  localparam int TENS_MAX = 5;

  typedef logic [BCD_W-1:0]  bcd_t;
  typedef logic [TENS_W-1:0] tens_t;

endpackage

// File: rtl/seconds_bcd_counter_digit.sv
// rtl/seconds_bcd_counter_digit.sv - one BCD digit that counts 0..MAX and carries on rollover
module bcd_digit_counter #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] digit,
  output logic         carry
);

  logic [W-1:0] digit_q;
  logic [W-1:0] digit_d;
  logic         at_max;

  assign at_max = (digit_q == W'(MAX));
  assign carry  = inc & at_max;
  assign digit  = digit_q;

  // next digit: wrap to zero past MAX so the digit can never hold an illegal code
  always_comb begin
    digit_d = digit_q;
    if (inc) begin
      digit_d = at_max ? '0 : digit_q + W'(1);
    end
  end

  // digit register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/seconds_bcd_counter.sv
// rtl/seconds_bcd_counter.sv - prescaled BCD seconds counter with valid/ready output; SECONDS_MINUTES_EN adds minutes
module seconds_bcd_counter
  import seconds_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int CMP_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              pause,
  input  logic              cmp_load,
  input  logic [CMP_W-1:0]  cmp_value,
  output logic              tick,
  output logic [BCD_W-1:0]  sec_ones,
  output logic [TENS_W-1:0] sec_tens,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef SECONDS_MINUTES_EN
  ,
  output logic [BCD_W-1:0]  min_ones,
  output logic [TENS_W-1:0] min_tens
`endif
);

  localparam logic [CMP_W-1:0] CMP_RST = CMP_W'(CLK_HZ - 1);

  logic [CMP_W-1:0] pcnt_q, pcnt_d;
  logic [CMP_W-1:0] cmp_q, cmp_d;
  logic             tick_q;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             run;
  logic             at_max;
  logic             wrap;
  logic             ovr_set;
  logic             sec_ones_carry;

  // prescaler, compare register and handshake next-state; a load always beats a coincident wrap
  always_comb begin
    run     = ena & ~pause;
    at_max  = (pcnt_q == cmp_q);
    wrap    = run & at_max & ~cmp_load;
    ovr_set = wrap & valid_q & ~out_ready;
    pcnt_d  = pcnt_q;
    cmp_d   = cmp_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (cmp_load) begin
      cmp_d  = cmp_value;
      pcnt_d = '0;
    end else if (run) begin
      pcnt_d = at_max ? '0 : pcnt_q + CMP_W'(1);
    end
    if (wrap) begin
      valid_d = 1'b1;
    end else if (valid_q & out_ready) begin
      valid_d = 1'b0;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // state registers; reset drops any pending update
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q  <= '0;
      cmp_q   <= CMP_RST;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      cmp_q   <= cmp_d;
      tick_q  <= wrap;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tick      = tick_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

  bcd_digit_counter #(.W(BCD_W), .MAX(ONES_MAX)) u_sec_ones (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap),
    .digit (sec_ones),
    .carry (sec_ones_carry)
  );

`ifdef SECONDS_MINUTES_EN
  logic sec_tens_carry;
  logic min_ones_carry;

  bcd_digit_counter #(.W(TENS_W), .MAX(TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_ones_carry),
    .digit (sec_tens),
    .carry (sec_tens_carry)
  );

  bcd_digit_counter #(.W(BCD_W), .MAX(ONES_MAX)) u_min_ones (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_tens_carry),
    .digit (min_ones),
    .carry (min_ones_carry)
  );

  bcd_digit_counter #(.W(TENS_W), .MAX(TENS_MAX)) u_min_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (min_ones_carry),
    .digit (min_tens),
    .carry ()
  );
`else
  bcd_digit_counter #(.W(TENS_W), .MAX(TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_ones_carry),
    .digit (sec_tens),
    .carry ()
  );
`endif

endmodule

// File: tb/tb_seconds_bcd_counter.sv
// tb/tb_seconds_bcd_counter.sv - self-checking bench for seconds_bcd_counter
module tb_seconds_bcd_counter;

  localparam int CLK_HZ = 16;
  localparam int CMP_W  = 8;
`ifdef SECONDS_MINUTES_EN
  localparam int MODN = 3600;
`else
  localparam int MODN = 60;
`endif

  logic             clk;
  logic             reset;
  logic             ena;
  logic             pause;
  logic             cmp_load;
  logic [CMP_W-1:0] cmp_value;
  logic             tick;
  logic [3:0]       sec_ones;
  logic [2:0]       sec_tens;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             ovr_clr;
`ifdef SECONDS_MINUTES_EN
  logic [3:0]       min_ones;
  logic [2:0]       min_tens;
`endif

  seconds_bcd_counter #(.CLK_HZ(CLK_HZ), .CMP_W(CMP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .pause     (pause),
    .cmp_load  (cmp_load),
    .cmp_value (cmp_value),
    .tick      (tick),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
`ifdef SECONDS_MINUTES_EN
    ,
    .min_ones  (min_ones),
    .min_tens  (min_tens)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // reference: cycles into the current second, total elapsed seconds, handshake flags
  int m_pcnt;
  int m_cmp;
  int m_cnt;
  bit m_tick;
  bit m_valid;
  bit m_ovr;

  typedef struct {
    logic       rst, en, pa, ld;
    logic [7:0] val;
    logic       rdy, clr;
    logic       e_tick;
    int         e_ones, e_tens;
    logic       e_valid, e_ovr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit run, wrap, set_ovr;
    if (reset) begin
      m_pcnt = 0; m_cmp = CLK_HZ - 1; m_cnt = 0;
      m_tick = 0; m_valid = 0; m_ovr = 0;
    end else begin
      run     = ena && !pause;
      wrap    = run && !cmp_load && (m_pcnt == m_cmp);
      set_ovr = wrap && m_valid && !out_ready;
      m_tick  = wrap;
      if (cmp_load) begin
        m_cmp  = int'(cmp_value);
        m_pcnt = 0;
      end else if (run) begin
        m_pcnt = wrap ? 0 : m_pcnt + 1;
      end
      if (wrap) begin
        m_cnt   = (m_cnt + 1) % MODN;
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (set_ovr) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("m_tick", tick, m_tick);
    chk("m_sec_ones", sec_ones, (m_cnt % 60) % 10);
    chk("m_sec_tens", sec_tens, (m_cnt % 60) / 10);
    chk("m_valid", out_valid, m_valid);
    chk("m_overrun", overrun, m_ovr);
`ifdef SECONDS_MINUTES_EN
    chk("m_min_ones", min_ones, (m_cnt / 60) % 10);
    chk("m_min_tens", min_tens, (m_cnt / 60) / 10);
`endif
  endtask

  task automatic idle_inputs();
    reset = 0; ena = 0; pause = 0; cmp_load = 0;
    cmp_value = '0; out_ready = 0; ovr_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic load(input int v, input logic rdy);
    ena = 1; cmp_load = 1; cmp_value = CMP_W'(v); out_ready = rdy;
    step();
    cmp_load = 0;
  endtask

  initial begin
    int nt;
    total = 0;
    bad   = 0;
    m_pcnt = 0; m_cmp = CLK_HZ - 1; m_cnt = 0;
    m_tick = 0; m_valid = 0; m_ovr = 0;
    idle_inputs();

    // rst en pa ld val rdy clr | tick ones tens valid ovr
    tbl[0]  = '{1, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 8'd2, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 8'd0, 0, 0, 1, 1, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 0, 8'd0, 0, 0, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 8'd0, 0, 0, 0, 1, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 8'd0, 0, 0, 1, 2, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 8'd0, 0, 1, 0, 2, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 8'd0, 1, 0, 0, 2, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 8'd0, 1, 0, 0, 2, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 8'd0, 1, 0, 0, 2, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 8'd2, 1, 0, 0, 2, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 8'd0, 1, 0, 0, 2, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 8'd0, 1, 0, 0, 2, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 8'd0, 1, 0, 1, 3, 0, 1, 0};
    tbl[16] = '{1, 0, 0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst; ena = tbl[i].en; pause = tbl[i].pa;
      cmp_load = tbl[i].ld; cmp_value = tbl[i].val;
      out_ready = tbl[i].rdy; ovr_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_tick", i), tick, tbl[i].e_tick);
      chk($sformatf("v%0d_ones", i), sec_ones, tbl[i].e_ones);
      chk($sformatf("v%0d_tens", i), sec_tens, tbl[i].e_tens);
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_ovr", i), overrun, tbl[i].e_ovr);
    end

    // tick every 4 cycles with compare 3; ten ticks read as 10
    do_reset();
    load(3, 1);
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick) nt++;
      chk("a_tick_phase", tick, int'(i % 4 == 3));
    end
    chk("a_ticks", nt, 10);
    chk("a_ones", sec_ones, 0);
    chk("a_tens", sec_tens, 1);

    // compare 0: a tick every cycle, 60 of them wrap 59 -> 00
    do_reset();
    load(0, 1);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("b_tick", tick, 1);
      chk("b_valid", out_valid, 1);
      chk("b_ovr", overrun, 0);
    end
    chk("b_ones", sec_ones, 0);
    chk("b_tens", sec_tens, 0);
`ifdef SECONDS_MINUTES_EN
    chk("b_min_ones", min_ones, 1);
    chk("b_min_tens", min_tens, 0);
`endif

    // pause at pcnt 2 of compare 5; four more running cycles to the tick
    do_reset();
    load(5, 1);
    step();
    step();
    pause = 1;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) nt++;
    end
    chk("c_paused_ticks", nt, 0);
    pause = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c_resume_tick", tick, int'(i == 3));
    end

    // reset while valid and count is 37
    do_reset();
    load(0, 1);
    for (int i = 0; i < 37; i++) step();
    chk("d_ones", sec_ones, 7);
    chk("d_tens", sec_tens, 3);
    chk("d_valid", out_valid, 1);
    reset = 1;
    step();
    reset = 0;
    chk("d_rst_tick", tick, 0);
    chk("d_rst_ones", sec_ones, 0);
    chk("d_rst_tens", sec_tens, 0);
    chk("d_rst_valid", out_valid, 0);
    chk("d_rst_ovr", overrun, 0);

    // randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      pause     = ($urandom_range(0, 9) == 0);
      cmp_load  = ($urandom_range(0, 39) == 0);
      cmp_value = CMP_W'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 1) == 1);
      ovr_clr   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
